output_bram_reader: RTL
=======================

Name: output_bram_reader

Overview:
- Read-side counterpart of the convolution adder stage that writes results into the Output BRAM.
- On a start pulse, walks one MAX_ROW x MAX_COL output feature map in raster order and issues BRAM reads.
- Absorbs the fixed BRAM read latency and streams the 16-bit half-precision results out on a valid/ready interface with row and frame markers.
- Feeds the next layer or the upscale stage.

Parameters:
- MAX_ROW, 5, rows in the feature map
- MAX_COL, 5, columns in the feature map
- ADDR_W, 18, Output BRAM address width
- DATA_W, 16, data width (fp16)
- BRAM_LAT, 2, Output BRAM read latency in clocks, from en/addr to valid data; range 1..4

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle request to read one full map
- busy  out  1  high from the start-accept edge until done
- done  out  1  one-cycle pulse after the final output handshake
- Output_BRAM_en  out  1  BRAM read enable
- Output_read_addr  out  ADDR_W  BRAM read address
- Output_read_data  in  DATA_W  BRAM read data, valid BRAM_LAT cycles after en
- m_data  out  DATA_W  streamed pixel
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accept
- m_row_end  out  1  qualifies m_data as last column of a row
- m_last  out  1  qualifies m_data as last pixel of the map

Behaviour:
- Reset (async, any time, including mid-frame):
  - busy, done, Output_BRAM_en, m_valid, m_row_end and m_last go to 0; Output_read_addr goes to 0.
  - FSM returns to IDLE.
  - Row/column counters, in-flight pipe valid bits and FIFO count are cleared, so in-flight read data is discarded.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE: start=1 -> ISSUE; busy=1 and issue address reset to 0 at the same edge.
  - ISSUE: one read per cycle while credit is available. After the read of address MAX_ROW*MAX_COL-1 is issued -> DRAIN.
  - DRAIN: no reads. When the last pixel handshake occurs (m_valid & m_ready & m_last) -> FIN.
  - FIN: done=1 and busy=0 for exactly one cycle -> IDLE.
  - start outside IDLE is ignored.
- Addressing:
  - Output_read_addr is registered and equals row*MAX_COL+col, implemented as an incrementing counter.
  - Row/column counters: col wraps at MAX_COL-1 to 0 and row increments on that wrap.
  - The address register holds its last value while Output_BRAM_en is 0.
- Read pipeline:
  - A shift chain of BRAM_LAT valid bits tracks in-flight reads.
  - Output_read_data is written into the output FIFO on the cycle its valid bit emerges.
  - Sideband row_end/last flags are computed at issue time and travel alongside in the chain.
- Output FIFO:
  - Depth BRAM_LAT+2, show-ahead (m_data/m_valid driven from the head entry).
  - Push and pop in the same cycle are allowed.
  - The FIFO never overflows: a read is issued only if (in-flight count + FIFO count - pop_this_cycle) < DEPTH.
- Throughput and latency:
  - With m_ready held high: one beat per cycle.
  - First m_valid appears BRAM_LAT+1 edges after the start-accept edge.
  - 25 beats for a 5x5 map.
- Backpressure:
  - m_data, m_row_end and m_last are stable while m_valid=1 and m_ready=0.
  - Issue stalls on zero credit and resumes automatically, with no data loss or duplication.
- Flag rules:
  - m_row_end=1 on col==MAX_COL-1.
  - m_last=1 only on the final pixel; m_row_end is also 1 on that beat.
- Arithmetic: data is passed through untouched; no fp16 interpretation.

Decomposition:
- Shared package holds:
  - fp16 data width
  - Output BRAM address width
  - default map dimensions (5x5)
  - BRAM_LAT default
  - FSM state encoding
- Sub-module stream_fifo: parameterised depth/width, show-ahead, count output, async reset. Holds {last, row_end, data}.
- Address/credit logic and FSM stay in the top module.

Test Plan:
- 5x5 map, BRAM model holds addr+16'h3C00, m_ready=1 -> start at edge 0:
  - first m_valid at edge 3, data 3C00
  - 25 consecutive beats, data 3C00..3C18
  - m_row_end on beats 4, 9, 14, 19, 24; m_last only on beat 24
  - done one cycle after beat 24
- Same map, m_ready toggling 1010...:
  - identical data order, no gaps in sequence
  - FIFO count never exceeds 4
  - Output_BRAM_en deasserts when credit is exhausted
- m_ready=0 for 20 cycles after start:
  - exactly 4 reads issued (addr 0..3)
  - m_data holds 3C00 stable
  - release -> remaining 21 addresses read, all 25 beats correct
- start pulsed again at beat 10 -> ignored; frame completes normally with a single done pulse.
- rst asserted mid-frame at beat 12 (async, between edges):
  - all outputs 0 immediately
  - following start reads addr 0 first and delivers a clean 25-beat frame
- BRAM_LAT=1, MAX_ROW=2, MAX_COL=3:
  - first m_valid at edge 2
  - 6 beats, m_row_end on beats 2 and 5, m_last on beat 5

Source files
------------

// File: rtl/output_bram_reader_pkg.sv
// Shared definitions for the Output BRAM read-back path: data/address widths,
// default feature-map geometry, BRAM latency and the reader FSM encoding.
package output_bram_reader_pkg;

   localparam int DATA_W_DEF   = 16;
   localparam int ADDR_W_DEF   = 18;
   localparam int MAX_ROW_DEF  = 5;
   localparam int MAX_COL_DEF  = 5;
   localparam int BRAM_LAT_DEF = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_e;

   // Two spare slots beyond the read latency keep full rate with m_ready high.
   function automatic int fifo_depth(input int bram_lat);
      return bram_lat + 2;
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small show-ahead FIFO: the head entry is always visible on head_data and
// count reports occupancy so the producer can run credit-based flow control.
module stream_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 18,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/output_bram_reader.sv
// Walks one output feature map in raster order, reads it from the Output BRAM
// and streams it on valid/ready with row and frame markers.
module output_bram_reader
   import output_bram_reader_pkg::*;
#(
   parameter int MAX_ROW  = MAX_ROW_DEF,
   parameter int MAX_COL  = MAX_COL_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int BRAM_LAT = BRAM_LAT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              Output_BRAM_en,
   output logic [ADDR_W-1:0] Output_read_addr,
   input  logic [DATA_W-1:0] Output_read_data,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_row_end,
   output logic              m_last
);

   localparam int DEPTH = fifo_depth(BRAM_LAT);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int OCC_W = $clog2(2 * DEPTH + 1);
   localparam int ROW_W = $clog2(MAX_ROW + 1);
   localparam int COL_W = $clog2(MAX_COL + 1);
   localparam int ENT_W = DATA_W + 2;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [BRAM_LAT-1:0] pipe_vld_q, pipe_vld_d;
   logic [BRAM_LAT-1:0] pipe_row_end_q, pipe_row_end_d;
   logic [BRAM_LAT-1:0] pipe_last_q, pipe_last_d;
   logic [CNT_W-1:0]    fifo_cnt;
   logic [ENT_W-1:0]    head;
   logic [OCC_W-1:0]    occupancy;
   logic                issue, pop, credit_ok;
   logic                row_end_now, last_now;

   assign row_end_now = (col_q == COL_W'(MAX_COL - 1));
   assign last_now    = row_end_now && (row_q == ROW_W'(MAX_ROW - 1));
   assign pop         = m_valid && m_ready;

   // Every read in flight already owns a FIFO slot; a slot freed by this cycle's pop is reusable.
   always_comb begin
      occupancy = OCC_W'(fifo_cnt);
      for (int i = 0; i < BRAM_LAT; i++) begin
         occupancy = occupancy + OCC_W'(pipe_vld_q[i]);
      end
      if (pop) begin
         occupancy = occupancy - OCC_W'(1);
      end
      credit_ok = (occupancy < OCC_W'(DEPTH));
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      row_d   = row_q;
      col_d   = col_q;
      issue   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ISSUE;
               addr_d  = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         S_ISSUE: begin
            busy = 1'b1;
            if (credit_ok) begin
               issue = 1'b1;
               if (last_now) begin
                  state_d = S_DRAIN;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
                  if (row_end_now) begin
                     col_d = '0;
                     row_d = row_q + ROW_W'(1);
                  end else begin
                     col_d = col_q + COL_W'(1);
                  end
               end
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (pop && m_last) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sideband flags ride with the valid bit so they meet their data at the FIFO input.
   always_comb begin
      pipe_vld_d        = pipe_vld_q;
      pipe_row_end_d    = pipe_row_end_q;
      pipe_last_d       = pipe_last_q;
      pipe_vld_d[0]     = issue;
      pipe_row_end_d[0] = row_end_now;
      pipe_last_d[0]    = last_now;
      for (int i = 1; i < BRAM_LAT; i++) begin
         pipe_vld_d[i]     = pipe_vld_q[i-1];
         pipe_row_end_d[i] = pipe_row_end_q[i-1];
         pipe_last_d[i]    = pipe_last_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         addr_q         <= '0;
         row_q          <= '0;
         col_q          <= '0;
         pipe_vld_q     <= '0;
         pipe_row_end_q <= '0;
         pipe_last_q    <= '0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         row_q          <= row_d;
         col_q          <= col_d;
         pipe_vld_q     <= pipe_vld_d;
         pipe_row_end_q <= pipe_row_end_d;
         pipe_last_q    <= pipe_last_d;
      end
   end

   stream_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (pipe_vld_q[BRAM_LAT-1]),
      .push_data ({pipe_last_q[BRAM_LAT-1], pipe_row_end_q[BRAM_LAT-1], Output_read_data}),
      .pop       (pop),
      .head_data (head),
      .count     (fifo_cnt)
   );

   assign Output_BRAM_en   = issue;
   assign Output_read_addr = addr_q;

   // Outputs are gated by valid so a reset or empty FIFO presents all zeros.
   assign m_valid   = (fifo_cnt != '0);
   assign m_data    = m_valid ? head[DATA_W-1:0] : '0;
   assign m_row_end = m_valid && head[DATA_W];
   assign m_last    = m_valid && head[DATA_W+1];

endmodule
